spi_reg_slave: RTL

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_slave_pkg.sv | 20 ++
 rtl/spi_reg_slave_if.sv | 26 ++
 rtl/spi_reg_slave_sync_edge.sv | 34 +++
 rtl/spi_reg_slave.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/spi_reg_slave_pkg.sv
// Shared types and command-byte layout for the SPI register slave.
// Everything that must agree between the FSM and its users lives here.
package spi_reg_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int ADDR_W = 5;

    // Command byte: [7:3] register address, [1] direction, [2] and [0] unused
    localparam int CMD_ADDR_MSB = 7;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_DIR_BIT  = 1;

    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between an initiator and the register slave.
interface spi_reg_slave_if;

    logic spi_SS_n;
    logic spi_SCLK;
    logic spi_MOSI;
    logic spi_MISO;
    logic spi_MISO_oe;

    modport master (
        output spi_SS_n,
        output spi_SCLK,
        output spi_MOSI,
        input  spi_MISO,
        input  spi_MISO_oe
    );

    modport slave (
        input  spi_SS_n,
        input  spi_SCLK,
        input  spi_MOSI,
        output spi_MISO,
        output spi_MISO_oe
    );

endinterface

// File: rtl/spi_reg_slave_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized value.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave fronting a bank of byte registers, with an auto-incrementing
// burst address and a local read/write port for the host logic.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | chip select high; SCLK ignored, MISO released
// ST_CMD  | shifting in command byte, shifting out status_in
// ST_DATA | data bytes: commit (write) or stream registers (read), addr++
module spi_reg_slave
    import spi_reg_slave_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    spi_reg_slave_if.slave    spi,
    input  logic [DATA_W-1:0] status_in,
    input  logic [ADDR_W-1:0] lcl_addr,
    output logic [DATA_W-1:0] lcl_rdata,
    input  logic              lcl_we,
    input  logic [DATA_W-1:0] lcl_wdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic ss_s, ss_rise, ss_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d_in    (spi.spi_SS_n),
        .q       (ss_s),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d_in    (spi.spi_SCLK),
        .q       (sclk_s),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d_in    (spi.spi_MOSI),
        .q       (mosi_s),
        .rise    (mosi_rise),
        .fall    (mosi_fall)
    );

    // The FSM works purely on edges; the remaining sync outputs are spare.
    logic unused_sync;
    assign unused_sync = ^{ss_s, sclk_s, mosi_rise, mosi_fall};

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [ADDR_W-1:0] addr;
    logic              dir;
    logic              miso_q;
    logic              miso_oe_q;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [DATA_W-1:0] rx_next;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] cmd_addr;
    logic              byte_done;
    logic              spi_we;

    assign rx_next   = {rx_shift[DATA_W-2:0], mosi_s};
    assign addr_nxt  = addr + ADDR_W'(1);
    assign cmd_addr  = rx_next[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign byte_done = sclk_rise && (bit_cnt == CNT_LAST);
    // A chip-select release seen in the same cycle abandons the byte.
    assign spi_we    = (state == ST_DATA) && byte_done && !ss_rise
                       && (dir == DIR_WRITE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            addr      <= '0;
            dir       <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (ss_rise) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ss_fall) begin
                            state     <= ST_CMD;
                            bit_cnt   <= '0;
                            tx_shift  <= status_in;
                            miso_q    <= status_in[DATA_W-1];
                            miso_oe_q <= 1'b1;
                        end
                    end
                    ST_CMD, ST_DATA: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= byte_done ? '0 : bit_cnt + CNT_W'(1);
                            if (byte_done) begin
                                if (state == ST_CMD) begin
                                    addr     <= cmd_addr;
                                    dir      <= rx_next[CMD_DIR_BIT];
                                    tx_shift <= regs[cmd_addr];
                                    state    <= ST_DATA;
                                end else begin
                                    if (dir == DIR_WRITE) begin
                                        wr_strobe <= 1'b1;
                                        wr_addr   <= addr;
                                    end
                                    addr     <= addr_nxt;
                                    tx_shift <= regs[addr_nxt];
                                end
                            end
                        end else if (sclk_fall) begin
                            // bit_cnt==0 here means a fresh byte was just loaded:
                            // present its MSB rather than shifting past it.
                            if (bit_cnt == '0) begin
                                miso_q <= tx_shift[DATA_W-1];
                            end else begin
                                miso_q   <= tx_shift[DATA_W-2];
                                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        miso_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // SPI commit is written last so it overrides a same-address local write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (lcl_we) begin
                regs[lcl_addr] <= lcl_wdata;
            end
            if (spi_we) begin
                regs[addr] <= rx_next;
            end
        end
    end

    assign lcl_rdata       = regs[lcl_addr];
    assign spi.spi_MISO    = miso_q;
    assign spi.spi_MISO_oe = miso_oe_q;

endmodule
